wb_stage_pipe: RTL and testbench
================================

Name: wb_stage_pipe

Overview:
Parametrised MIPS write-back stage with an integrated MEM/WB pipeline register. It selects the write-back source (ALU result, memory load, or link address PC+4) and extracts sub-word loads (byte/half, signed or unsigned). It honours pipeline Stall/Flush and drives the register-file write port one cycle after capture. It sits between the memory stage and the register file, replacing the fixed 32-bit two-source write-back mux.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
ADDR_W, 5, register-specifier width.
ZERO_GUARD, 1, when 1 a write to register 0 is suppressed (RegWrite_out forced 0).
CNT_W, 16, width of the retired-instruction counter.

Ports:
Clk  in  1  rising-edge clock.
Rst_n  in  1  asynchronous active-low reset.
Stall  in  1  hold the pipeline register.
Flush  in  1  squash: next register content becomes a bubble.
Valid_in  in  1  incoming slot holds a real instruction.
ReadData  in  DATA_W  word read from data memory.
ALUResult  in  DATA_W  ALU result; bits [1:0] also give the load byte offset.
PCPlus4  in  DATA_W  link address for JAL/JALR.
Address  in  ADDR_W  destination register.
WbSel  in  2  00=ALU, 01=memory, 10=PC+4, 11=ALU (reserved).
LoadSize  in  2  00=word, 01=half, 10=byte, 11=word.
LoadUnsigned  in  1  1=zero-extend sub-word load, 0=sign-extend.
RegWrite  in  1  instruction writes the register file.
WriteData_out  out  DATA_W  register-file write data.
WriteRegister  out  ADDR_W  register-file write address.
RegWrite_out  out  1  register-file write enable.
Valid_out  out  1  registered slot is valid.
RetireCount  out  CNT_W  count of valid instructions captured.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - WriteData_out=0, WriteRegister=0, RegWrite_out=0, Valid_out=0, RetireCount=0.
  - Deassertion takes effect on the next Clk edge.
- Combinational front end, evaluated before the register:
  - off = ALUResult[1:0], little-endian.
  - Byte load: selects ReadData[8*off+7 : 8*off].
  - Half load: selects ReadData[16*off[1]+15 : 16*off[1]]; off[0] is ignored (no misalignment trap).
  - Sub-word value is extended to DATA_W: sign-extended if LoadUnsigned=0, zero-extended if 1.
  - Word load with DATA_W=64: ReadData[31:0] sign-extended, or zero-extended if LoadUnsigned=1.
  - Result = mux(WbSel) of ALUResult, extracted load, PCPlus4.
- Per rising edge, priority order:
  - Flush: Valid_out=0, RegWrite_out=0, WriteData_out=0, WriteRegister=0; RetireCount unchanged.
  - else Stall: all outputs hold their values. RegWrite_out stays asserted if it was asserted; a repeated write of the same value is harmless.
  - else capture:
    - Valid_out <= Valid_in; WriteData_out <= result; WriteRegister <= Address.
    - RegWrite_out <= RegWrite & Valid_in & ~(ZERO_GUARD & (Address==0)).
    - RetireCount += 1 when Valid_in=1.
- Latency is exactly 1 cycle from a capture edge to the outputs.
- Flush and Stall asserted together: Flush wins.
- RetireCount wraps from 2^CNT_W-1 to 0 silently.
- A captured bubble (Valid_in=0) still loads data and address, but RegWrite_out=0.
- Reset asserted mid-operation clears all state immediately; there is no pending-write replay.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then Rst_n=1, WbSel=00, ALUResult=0x0000_1234, Address=8, RegWrite=1, Valid_in=1, one edge -> WriteData_out=0x0000_1234, WriteRegister=8, RegWrite_out=1, RetireCount=1.
2. Signed byte load: WbSel=01, LoadSize=10, LoadUnsigned=0, ReadData=0x80FF_7F01, ALUResult[1:0]=3 -> 0xFFFF_FF80. Repeat with LoadUnsigned=1 -> 0x0000_0080.
3. Half load, off=2, ReadData=0x8001_0000: signed -> 0xFFFF_8001; unsigned -> 0x0000_8001. Word load with DATA_W=64 and ReadData[31:0]=0x8000_0000, signed -> 0xFFFF_FFFF_8000_0000.
4. JAL: WbSel=10, PCPlus4=0x0040_0010, Address=31 -> WriteData_out=0x0040_0010, RegWrite_out=1. Then Address=0, RegWrite=1 -> RegWrite_out=0, Valid_out=1, counter increments.
5. Stall for 3 cycles with changing inputs -> outputs frozen. Stall=1 and Flush=1 together -> Valid_out=0, RegWrite_out=0, RetireCount unchanged.
6. CNT_W=4: capture 17 valid instructions -> RetireCount=1 after the wrap. Assert Rst_n=0 between edges -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// MIPS write-back stage with integrated MEM/WB register: source select, sub-word
// load extraction, stall/flush handling and a retired-instruction counter.
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int ZERO_GUARD = 1,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Valid_in,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        WbSel,
    input  logic [1:0]        LoadSize,
    input  logic              LoadUnsigned,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] WriteData_out,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic              RegWrite_out,
    output logic              Valid_out,
    output logic [CNT_W-1:0]  RetireCount
);

    localparam logic ZG = (ZERO_GUARD != 0);

    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [DATA_W-1:0] word_ext_s;
    logic [DATA_W-1:0] load_s;
    logic [DATA_W-1:0] result_s;
    logic              we_s;

    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic              we_q, we_d;
    logic              vld_q, vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // On a 64-bit datapath a word load is only 32 bits wide and must be extended.
    generate
        if (DATA_W > 32) begin : g_word_ext
            assign word_ext_s = {{(DATA_W-32){ReadData[31] & ~LoadUnsigned}}, ReadData[31:0]};
        end else begin : g_word_pass
            assign word_ext_s = ReadData;
        end
    endgenerate

    // Sub-word extraction and write-back source selection.
    always_comb begin
        byte_s   = ReadData[7:0];
        half_s   = ReadData[15:0];
        load_s   = word_ext_s;
        result_s = ALUResult;
        case (ALUResult[1:0])
            2'b00:   byte_s = ReadData[7:0];
            2'b01:   byte_s = ReadData[15:8];
            2'b10:   byte_s = ReadData[23:16];
            default: byte_s = ReadData[31:24];
        endcase
        if (ALUResult[1]) begin
            half_s = ReadData[31:16];
        end else begin
            half_s = ReadData[15:0];
        end
        case (LoadSize)
            2'b01:   load_s = {{(DATA_W-16){half_s[15] & ~LoadUnsigned}}, half_s};
            2'b10:   load_s = {{(DATA_W-8){byte_s[7] & ~LoadUnsigned}}, byte_s};
            default: load_s = word_ext_s;
        endcase
        case (WbSel)
            2'b01:   result_s = load_s;
            2'b10:   result_s = PCPlus4;
            default: result_s = ALUResult;
        endcase
    end

    assign we_s = RegWrite & Valid_in & ~(ZG & (Address == {ADDR_W{1'b0}}));

    // Next-state of the pipeline register: flush beats stall beats capture.
    always_comb begin
        data_d = data_q;
        wreg_d = wreg_q;
        we_d   = we_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (Flush) begin
            data_d = {DATA_W{1'b0}};
            wreg_d = {ADDR_W{1'b0}};
            we_d   = 1'b0;
            vld_d  = 1'b0;
        end else if (Stall) begin
            data_d = data_q;
        end else begin
            data_d = result_s;
            wreg_d = Address;
            we_d   = we_s;
            vld_d  = Valid_in;
            if (Valid_in) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Pipeline register and retire counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_q <= {DATA_W{1'b0}};
            wreg_q <= {ADDR_W{1'b0}};
            we_q   <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            data_q <= data_d;
            wreg_q <= wreg_d;
            we_q   <= we_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign WriteData_out = data_q;
    assign WriteRegister = wreg_q;
    assign RegWrite_out  = we_q;
    assign Valid_out     = vld_q;
    assign RetireCount   = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench: a 32-bit/CNT_W=4 and a 64-bit/CNT_W=16 instance share stimulus.
module tb_wb_stage_pipe;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, vin = 1'b0, uns = 1'b0, rw = 1'b0;
    logic [63:0] rd = 64'h0, alu = 64'h0, pc = 64'h0;
    logic [4:0]  addr = 5'd0;
    logic [1:0]  wbsel = 2'd0, lsize = 2'd0;

    logic [31:0] wd0;
    logic [4:0]  wr0, wr1;
    logic        we0, we1, v0, v1;
    logic [3:0]  cnt0;
    logic [63:0] wd1;
    logic [15:0] cnt1;

    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  wreg;
        logic        we;
        logic        vld;
        logic [15:0] cnt;
    } exp_t;

    exp_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];

    always #5 Clk = ~Clk;

    wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_GUARD(1), .CNT_W(4)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(stall), .Flush(flush), .Valid_in(vin),
        .ReadData(rd[31:0]), .ALUResult(alu[31:0]), .PCPlus4(pc[31:0]), .Address(addr),
        .WbSel(wbsel), .LoadSize(lsize), .LoadUnsigned(uns), .RegWrite(rw),
        .WriteData_out(wd0), .WriteRegister(wr0), .RegWrite_out(we0), .Valid_out(v0),
        .RetireCount(cnt0));

    wb_stage_pipe #(.DATA_W(64), .ADDR_W(5), .ZERO_GUARD(1), .CNT_W(16)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(stall), .Flush(flush), .Valid_in(vin),
        .ReadData(rd), .ALUResult(alu), .PCPlus4(pc), .Address(addr),
        .WbSel(wbsel), .LoadSize(lsize), .LoadUnsigned(uns), .RegWrite(rw),
        .WriteData_out(wd1), .WriteRegister(wr1), .RegWrite_out(we1), .Valid_out(v1),
        .RetireCount(cnt1));

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-back value from the instruction-set rules, using plain arithmetic.
    function automatic logic [63:0] calc(input int dw);
        logic [63:0] mask;
        logic [63:0] rdv;
        longint      v;
        int          off;
        mask = (dw == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        rdv  = rd & mask;
        off  = int'(alu[1:0]);
        if (wbsel == 2'd2) return pc & mask;
        if (wbsel != 2'd1) return alu & mask;
        if (lsize == 2'd2) begin
            v = longint'((rdv >> (8 * off)) & 64'hFF);
            if (!uns && v >= 128) v = v - 256;
        end else if (lsize == 2'd1) begin
            v = longint'((rdv >> (16 * (off / 2))) & 64'hFFFF);
            if (!uns && v >= 32768) v = v - 65536;
        end else if (dw == 64) begin
            v = longint'(rdv & 64'hFFFF_FFFF);
            if (!uns && v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
        end else begin
            v = longint'(rdv);
        end
        return 64'(v) & mask;
    endfunction

    function automatic exp_t next_st(input exp_t s, input int dw, input int cw);
        exp_t n = s;
        if (flush) begin
            n.data = 64'h0; n.wreg = 5'd0; n.we = 1'b0; n.vld = 1'b0;
        end else if (!stall) begin
            n.data = calc(dw);
            n.wreg = addr;
            n.vld  = vin;
            n.we   = rw && vin && (addr != 5'd0);
            if (vin) n.cnt = 16'((32'(s.cnt) + 1) % (1 << cw));
        end
        return n;
    endfunction

    function automatic exp_t zero_st();
        exp_t z;
        z.data = 64'h0; z.wreg = 5'd0; z.we = 1'b0; z.vld = 1'b0; z.cnt = 16'd0;
        return z;
    endfunction

    task automatic cycle();
        m0 = next_st(m0, 32, 4);
        m1 = next_st(m1, 64, 16);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk_zero(input string tag);
        cmp({tag, ".wd0"}, {32'h0, wd0}, 64'h0);
        cmp({tag, ".wr0"}, {59'h0, wr0}, 64'h0);
        cmp({tag, ".we0"}, {63'h0, we0}, 64'h0);
        cmp({tag, ".v0"},  {63'h0, v0},  64'h0);
        cmp({tag, ".cnt0"}, {60'h0, cnt0}, 64'h0);
        cmp({tag, ".wd1"}, wd1, 64'h0);
        cmp({tag, ".cnt1"}, {48'h0, cnt1}, 64'h0);
        cmp({tag, ".v1"},  {63'h0, v1},  64'h0);
    endtask

    task automatic set_in(input logic [1:0] ws, input logic [1:0] ls, input logic u,
                          input logic [63:0] r, input logic [63:0] a, input logic [4:0] ad);
        wbsel = ws; lsize = ls; uns = u; rd = r; alu = a; addr = ad;
        rw = 1'b1; vin = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    // Monitor: every clock the registered outputs are popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("d0.data", {32'h0, wd0}, e.data);
                cmp("d0.wreg", {59'h0, wr0}, {59'h0, e.wreg});
                cmp("d0.we",   {63'h0, we0}, {63'h0, e.we});
                cmp("d0.vld",  {63'h0, v0},  {63'h0, e.vld});
                cmp("d0.cnt",  {60'h0, cnt0}, {48'h0, e.cnt});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("d1.data", wd1, e.data);
                cmp("d1.wreg", {59'h0, wr1}, {59'h0, e.wreg});
                cmp("d1.we",   {63'h0, we1}, {63'h0, e.we});
                cmp("d1.vld",  {63'h0, v1},  {63'h0, e.vld});
                cmp("d1.cnt",  {48'h0, cnt1}, {48'h0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m0 = zero_st();
        m1 = zero_st();
        #2;
        chk_zero("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        set_in(2'd0, 2'd0, 1'b0, 64'h0, 64'h0000_1234, 5'd8);
        cycle();
        cmp("t1.data", {32'h0, wd0}, 64'h0000_1234);
        cmp("t1.cnt", {48'h0, cnt1}, 64'd1);

        set_in(2'd1, 2'd2, 1'b0, 64'h80FF_7F01, 64'h3, 5'd9);
        cycle();
        cmp("t2.sbyte32", {32'h0, wd0}, 64'hFFFF_FF80);
        cmp("t2.sbyte64", wd1, 64'hFFFF_FFFF_FFFF_FF80);
        uns = 1'b1;
        cycle();
        cmp("t2.ubyte", wd1, 64'h80);

        set_in(2'd1, 2'd1, 1'b0, 64'h8001_0000, 64'h2, 5'd10);
        cycle();
        cmp("t3.shalf", {32'h0, wd0}, 64'hFFFF_8001);
        uns = 1'b1;
        cycle();
        cmp("t3.uhalf", {32'h0, wd0}, 64'h0000_8001);
        set_in(2'd1, 2'd0, 1'b0, 64'h1234_5678_8000_0000, 64'h0, 5'd11);
        cycle();
        cmp("t3.sword64", wd1, 64'hFFFF_FFFF_8000_0000);
        cmp("t3.word32", {32'h0, wd0}, 64'h8000_0000);

        set_in(2'd2, 2'd0, 1'b0, 64'h0, 64'h0, 5'd31);
        pc = 64'h0040_0010;
        cycle();
        cmp("t4.jal", {32'h0, wd0}, 64'h0040_0010);
        cmp("t4.we", {63'h0, we0}, 64'h1);
        addr = 5'd0;
        cycle();
        cmp("t4.r0we", {63'h0, we1}, 64'h0);
        cmp("t4.r0vld", {63'h0, v1}, 64'h1);
        cmp("t4.cnt", {48'h0, cnt1}, 64'd8);

        repeat (3) begin
            rd = {$urandom, $urandom}; alu = {$urandom, $urandom}; addr = 5'($urandom);
            stall = 1'b1;
            cycle();
        end
        flush = 1'b1;
        cycle();
        cmp("t5.flush.vld", {63'h0, v0}, 64'h0);
        cmp("t5.flush.cnt", {48'h0, cnt1}, 64'd8);

        for (int i = 0; i < 300; i++) begin
            rd = {$urandom, $urandom}; alu = {$urandom, $urandom}; pc = {$urandom, $urandom};
            addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wbsel = 2'($urandom); lsize = 2'($urandom); uns = 1'($urandom);
            rw = 1'($urandom); vin = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        Rst_n = 1'b0;
        m0 = zero_st();
        m1 = zero_st();
        #1;
        chk_zero("rst2");
        @(negedge Clk);
        Rst_n = 1'b1;
        set_in(2'd0, 2'd0, 1'b0, 64'h0, 64'h55, 5'd3);
        for (int i = 0; i < 17; i++) begin
            alu = {$urandom, $urandom};
            cycle();
        end
        cmp("t6.wrap4", {60'h0, cnt0}, 64'd1);
        cmp("t6.cnt16", {48'h0, cnt1}, 64'd17);

        cycle();
        #2;
        Rst_n = 1'b0;
        m0 = zero_st();
        m1 = zero_st();
        #1;
        chk_zero("async");
        @(negedge Clk);
        @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
